ahb_uart_rx_ctrl: RTL and testbench
===================================

// Module: ahb_uart_rx_ctrl
// PURPOSE
//  AHB-Lite slave controller for the UART_RX receiver.
//  - Captures each o_RX_DV/o_RX_Byte pulse into a receive FIFO.
//  - Tracks overrun and raises a level interrupt.
//  - Exposes DATA/STATUS/CTRL/THRESH registers to the CPU on the AHB bus.
//  - Sits between the UART_RX instance and the bus decoder. UART_RX runs on HCLK.
// PARAMETERS
//  FIFO_DEPTH  16  receive FIFO entries; power of 2, >=2
//  CNT_W       $clog2(FIFO_DEPTH)+1  localparam: occupancy width (0..FIFO_DEPTH)
// PORTS
//  HCLK       in   1      single clock, rising edge
//  HRESETn    in   1      asynchronous active-low reset
//  HSEL       in   1      slave select
//  HADDR      in   4      byte address; bits [3:2] select the register
//  HTRANS     in   2      AHB transfer type; HTRANS[1]=1 means NONSEQ/SEQ
//  HWRITE     in   1      1 = write
//  HSIZE      in   3      ignored; all accesses are treated as 32-bit
//  HREADY     in   1      bus ready (previous data phase is done)
//  HWDATA     in   32     write data, sampled in the data phase
//  HRDATA     out  32     read data, valid in the data phase
//  HREADYOUT  out  1      tied 1; no wait states
//  HRESP      out  1      tied 0; OKAY
//  i_rx_dv    in   1      one-cycle byte-valid pulse from UART_RX
//  i_rx_byte  in   8      received byte; valid while i_rx_dv=1
//  o_rx_irq   out  1      registered level interrupt
// BEHAVIOUR
//  Reset: FIFO empty, overrun=0, CTRL=0 (receiver disabled), THRESH=1, o_rx_irq=0, HRDATA=0.
//  Address phase: accepted when HSEL & HTRANS[1] & HREADY.
//   - Register HADDR[3:2], HWRITE and a valid flag.
//   - The data phase is the next cycle. Back-to-back transfers are supported.
//  Register map:
//   0x0 DATA    RO  [8]=valid, [7:0]=FIFO head.
//                   Reading a non-empty FIFO pops it at the end of the data phase.
//                   Reading an empty FIFO returns 0 and does not pop.
//   0x4 STATUS  R/W1C  [0]=not_empty, [1]=full, [2]=overrun (W1C), [8+:CNT_W]=count.
//   0x8 CTRL    RW  [0]=rx_en, [1]=irq_en.
//                   [2]=flush: write-1, self-clearing, reads 0; empties the FIFO.
//   0xC THRESH  RW  [CNT_W-1:0]=irq level. A write of 0 is stored as 1.
//  HRDATA: combinational from the registered address during a read data phase; 0 otherwise.
//  Writes: the HWDATA value takes effect at the end of the data phase.
//  Push: when i_rx_dv & rx_en.
//   - rx_en=0: bytes are dropped silently; overrun is not set.
//   - Full with no pop in the same cycle: byte dropped, overrun set (sticky).
//   - Full with a pop in the same cycle: push and pop both occur; count unchanged; no overrun.
//  Pointers: wrap modulo FIFO_DEPTH. count = push - pop, saturating at 0..FIFO_DEPTH.
//  Simultaneous events:
//   - Flush in the same cycle as a push: flush wins; the byte is discarded; no overrun.
//   - Overrun W1C in the same cycle as a new overrun: set wins.
//   - Read of DATA in the same cycle as a push into an empty FIFO: returns valid=0;
//     the new byte stays in the FIFO.
//  o_rx_irq: registered each cycle as irq_en & ((count >= THRESH) | overrun).
//   - Changes one cycle after its cause.
//  Reset mid-operation: all state returns to reset values immediately; partial AHB phases are abandoned.
// STRUCTURE
//  Package ahb_uart_rx_pkg:
//   - register offsets REG_DATA/REG_STATUS/REG_CTRL/REG_THRESH
//   - bit-position constants for STATUS and CTRL
//  Sub-module rx_byte_fifo:
//   - synchronous FIFO, DEPTH parameter, 8-bit data
//   - ports: push, pop, flush, head, count, full, empty
//   - asynchronous active-low reset
//  Top level: AHB address-phase register, register file, read mux, IRQ flop.
// TESTING
//  1. Reset, then read all 4 registers -> DATA=0, STATUS=0, CTRL=0, THRESH=1; o_rx_irq=0.
//  2. CTRL=0x1; push 0x55, then 0xA3 -> STATUS count=2, not_empty=1.
//     Read DATA -> 0x155, then 0x1A3, then 0x000.
//  3. Fill 16 bytes; push 0x7E -> full=1, overrun=1, 0x7E lost.
//     W1C STATUS=0x4 -> overrun=0; FIFO contents intact.
//  4. Full FIFO: DATA read and push in the same cycle -> count stays 16; overrun=0;
//     the new byte is read last.
//  5. CTRL=0x3, THRESH=4; push 3 bytes -> irq=0. Push a 4th -> irq=1 one cycle later.
//     Read 1 byte -> irq=0.
//  6. Push 5 bytes; write CTRL=0x5 (flush) -> count=0, CTRL reads 0x1.
//     Assert HRESETn=0 mid-transfer -> all reset values.
//     rx_en=0 with a push -> count stays 0.

Source files
------------

// File: rtl/ahb_uart_rx_ctrl_pkg.sv
// Shared definitions for the AHB-Lite UART receive controller: register selects
// and bit positions inside the STATUS, CTRL and DATA registers.
package ahb_uart_rx_pkg;

    // Word select taken from HADDR[3:2].
    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_sel_e;

    localparam int DATA_VALID     = 8;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_COUNT_LSB = 8;

    localparam int CTRL_RX_EN     = 0;
    localparam int CTRL_IRQ_EN    = 1;
    localparam int CTRL_FLUSH     = 2;

    // What the address phase leaves behind for the following data phase.
    typedef struct packed {
        logic     valid;
        logic     write;
        reg_sel_e addr;
    } ahb_dphase_t;

endpackage

// File: rtl/ahb_uart_rx_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the UART receive controller.
interface ahb_uart_rx_ctrl_if;
    logic        HSEL;
    logic [3:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HREADY, HWDATA,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb_uart_rx_ctrl_fifo.sv
// Synchronous byte FIFO for received UART data; flush overrides push and pop,
// and a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module rx_byte_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [7:0]       din,
    output logic [7:0]       head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign head    = mem[rd_ptr];
    assign count   = count_q;

    // Pointers are exactly AW bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ahb_uart_rx_ctrl.sv
// AHB-Lite slave in front of UART_RX: buffers received bytes in a FIFO and
// exposes DATA/STATUS/CTRL/THRESH registers plus a level interrupt.
module ahb_uart_rx_ctrl
    import ahb_uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    ahb_uart_rx_ctrl_if.slave  bus,
    input  logic               i_rx_dv,
    input  logic [7:0]         i_rx_byte,
    output logic               o_rx_irq
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    ahb_dphase_t      dphase;
    logic             addr_accept;
    logic             rd_en;
    logic             wr_en;
    logic             rx_en;
    logic             irq_en;
    logic [CNT_W-1:0] thresh;
    logic             overrun;
    logic             push_req;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             ovr_set;
    logic             ovr_clr;
    logic [7:0]       fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [31:0]      hrdata;
    logic             unused_bus;

    assign addr_accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dphase <= '0;
        end else begin
            dphase.valid <= addr_accept;
            dphase.write <= bus.HWRITE;
            dphase.addr  <= reg_sel_e'(bus.HADDR[3:2]);
        end
    end

    assign rd_en      = dphase.valid & ~dphase.write;
    assign wr_en      = dphase.valid &  dphase.write;
    assign push_req   = i_rx_dv & rx_en;
    assign fifo_pop   = rd_en & (dphase.addr == REG_DATA) & ~fifo_empty;
    assign fifo_flush = wr_en & (dphase.addr == REG_CTRL) & bus.HWDATA[CTRL_FLUSH];
    assign ovr_set    = push_req & fifo_full & ~fifo_pop & ~fifo_flush;
    assign ovr_clr    = wr_en & (dphase.addr == REG_STATUS) & bus.HWDATA[STAT_OVERRUN];

    rx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (push_req),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (i_rx_byte),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A zero threshold would hold the interrupt permanently, so it is stored as 1.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_en    <= 1'b0;
            irq_en   <= 1'b0;
            thresh   <= CNT_W'(1);
            overrun  <= 1'b0;
            o_rx_irq <= 1'b0;
        end else begin
            if (wr_en && dphase.addr == REG_CTRL) begin
                rx_en  <= bus.HWDATA[CTRL_RX_EN];
                irq_en <= bus.HWDATA[CTRL_IRQ_EN];
            end
            if (wr_en && dphase.addr == REG_THRESH) begin
                thresh <= (bus.HWDATA[CNT_W-1:0] == '0) ? CNT_W'(1) : bus.HWDATA[CNT_W-1:0];
            end
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
            o_rx_irq <= irq_en & ((fifo_count >= thresh) | overrun);
        end
    end

    always_comb begin
        hrdata = '0;
        if (rd_en) begin
            case (dphase.addr)
                REG_DATA: begin
                    if (!fifo_empty) begin
                        hrdata[DATA_VALID] = 1'b1;
                        hrdata[7:0]        = fifo_head;
                    end
                end
                REG_STATUS: begin
                    hrdata[STAT_NOT_EMPTY]              = ~fifo_empty;
                    hrdata[STAT_FULL]                   = fifo_full;
                    hrdata[STAT_OVERRUN]                = overrun;
                    hrdata[STAT_COUNT_LSB +: CNT_W]     = fifo_count;
                end
                REG_CTRL: begin
                    hrdata[CTRL_RX_EN]  = rx_en;
                    hrdata[CTRL_IRQ_EN] = irq_en;
                end
                REG_THRESH: begin
                    hrdata[CNT_W-1:0] = thresh;
                end
                default: hrdata = '0;
            endcase
        end
    end

    assign bus.HRDATA    = hrdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;

    assign unused_bus = ^{bus.HSIZE, bus.HTRANS[0], bus.HADDR[1:0], bus.HWDATA};

endmodule

// File: tb/tb_ahb_uart_rx_ctrl.sv
// Bench for ahb_uart_rx_ctrl: directed register scenarios plus random bus and
// receive traffic, all compared every cycle against a queue-based model.
module tb_ahb_uart_rx_ctrl;

    localparam int DEPTH = 16;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic        i_rx_dv;
    logic [7:0]  i_rx_byte;
    logic        o_rx_irq;

    ahb_uart_rx_ctrl_if bus();

    ahb_uart_rx_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .bus       (bus.slave),
        .i_rx_dv   (i_rx_dv),
        .i_rx_byte (i_rx_byte),
        .o_rx_irq  (o_rx_irq)
    );

    always #5 HCLK = ~HCLK;

    logic [7:0]  m_q[$];
    bit          m_ovr, m_rx_en, m_irq_en, m_irq;
    int          m_thr;
    bit          m_dp_v, m_dp_w;
    logic [1:0]  m_dp_a;

    logic [31:0] exp_rdata;
    bit          exp_irq;
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_rdata;
    logic        last_irq;
    logic [31:0] rd;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ovr    = 1'b0;
        m_rx_en  = 1'b0;
        m_irq_en = 1'b0;
        m_irq    = 1'b0;
        m_thr    = 1;
        m_dp_v   = 1'b0;
        m_dp_w   = 1'b0;
        m_dp_a   = 2'd0;
    endfunction

    // Register view the CPU should see in the current data phase.
    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        int sz;
        r  = '0;
        sz = m_q.size();
        if (m_dp_v && !m_dp_w) begin
            case (m_dp_a)
                2'd0: if (sz > 0) begin r[8] = 1'b1; r[7:0] = m_q[0]; end
                2'd1: begin
                    r[12:8] = 5'(sz);
                    r[2]    = m_ovr;
                    r[1]    = (sz == DEPTH);
                    r[0]    = (sz != 0);
                end
                2'd2: begin r[0] = m_rx_en; r[1] = m_irq_en; end
                default: r[4:0] = 5'(m_thr);
            endcase
        end
        return r;
    endfunction

    // Advances the model across one clock edge using the inputs driven this cycle.
    task automatic model_step();
        int sz;
        bit pop, flush, push_req, set_ovr, full_before, irq_next;
        sz          = m_q.size();
        irq_next    = m_irq_en && ((sz >= m_thr) || m_ovr);
        full_before = (sz == DEPTH);
        pop         = m_dp_v && !m_dp_w && (m_dp_a == 2'd0) && (sz > 0);
        flush       = m_dp_v && m_dp_w && (m_dp_a == 2'd2) && bus.HWDATA[2];
        push_req    = i_rx_dv && m_rx_en;
        set_ovr     = 1'b0;
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push_req) begin
                if (!full_before || pop) m_q.push_back(i_rx_byte);
                else set_ovr = 1'b1;
            end
        end
        if (set_ovr) m_ovr = 1'b1;
        else if (m_dp_v && m_dp_w && m_dp_a == 2'd1 && bus.HWDATA[2]) m_ovr = 1'b0;
        if (m_dp_v && m_dp_w && m_dp_a == 2'd2) begin
            m_rx_en  = bus.HWDATA[0];
            m_irq_en = bus.HWDATA[1];
        end
        if (m_dp_v && m_dp_w && m_dp_a == 2'd3) begin
            m_thr = int'(bus.HWDATA[4:0]);
            if (m_thr == 0) m_thr = 1;
        end
        m_irq  = irq_next;
        m_dp_v = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
        m_dp_w = bus.HWRITE;
        m_dp_a = bus.HADDR[3:2];
    endtask

    task automatic applyStimulus(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [3:0] addr, input logic [31:0] wdata,
                                 input logic rdy, input logic dv, input logic [7:0] b);
        bus.HSEL   = sel;
        bus.HTRANS = trans;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        bus.HSIZE  = 3'b010;
        bus.HREADY = rdy;
        bus.HWDATA = wdata;
        i_rx_dv    = dv;
        i_rx_byte  = b;
        exp_rdata  = model_rdata();
        exp_irq    = m_irq;
        @(negedge HCLK);
        last_rdata = bus.HRDATA;
        last_irq   = o_rx_irq;
        @(posedge HCLK);
        #1;
        model_step();
    endtask

    task automatic drive_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 4'h0;
        bus.HSIZE  = 3'b010;
        bus.HREADY = 1'b1;
        bus.HWDATA = '0;
        i_rx_dv    = 1'b0;
        i_rx_byte  = 8'h00;
    endtask

    task automatic doReset(input int cycles);
        HRESETn = 1'b0;
        drive_idle();
        model_reset();
        exp_rdata = '0;
        exp_irq   = 1'b0;
        repeat (cycles) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic push_byte(input logic [7:0] b);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 32'h0, 1'b1, 1'b1, b);
    endtask

    task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 2'b10, 1'b1, addr, 32'h0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, data, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic ahb_read_push(input logic [3:0] addr, input logic dv, input logic [7:0] b,
                                 output logic [31:0] data);
        applyStimulus(1'b1, 2'b10, 1'b0, addr, 32'h0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 2'b00, 1'b0, 4'h0, 32'h0, 1'b1, dv, b);
        data = last_rdata;
    endtask

    task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
        ahb_read_push(addr, 1'b0, 8'h00, data);
    endtask

    // The one compare process: every cycle, DUT outputs against the model.
    always @(negedge HCLK) begin
        if (chk_en) begin
            checkOutput("hrdata", bus.HRDATA, exp_rdata);
            checkOutput("irq", {31'b0, o_rx_irq}, {31'b0, exp_irq});
        end
    end

    initial begin
        logic [31:0] wd;
        drive_idle();
        model_reset();
        exp_rdata = '0;
        exp_irq   = 1'b0;
        #1;
        chk_en = 1'b1;
        doReset(3);

        $display("[TB] reset values");
        ahb_read(4'h0, rd); checkOutput("rst_data", rd, 32'h0);
        ahb_read(4'h4, rd); checkOutput("rst_status", rd, 32'h0);
        ahb_read(4'h8, rd); checkOutput("rst_ctrl", rd, 32'h0);
        ahb_read(4'hC, rd); checkOutput("rst_thresh", rd, 32'h1);
        checkOutput("rst_irq", {31'b0, last_irq}, 32'h0);
        checkOutput("hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
        checkOutput("hresp", {31'b0, bus.HRESP}, 32'h0);

        $display("[TB] basic receive");
        ahb_write(4'h8, 32'h1);
        push_byte(8'h55);
        push_byte(8'hA3);
        ahb_read(4'h4, rd); checkOutput("two_status", rd, 32'h201);
        ahb_read(4'h0, rd); checkOutput("pop_55", rd, 32'h155);
        ahb_read(4'h0, rd); checkOutput("pop_a3", rd, 32'h1A3);
        ahb_read(4'h0, rd); checkOutput("pop_empty", rd, 32'h0);

        $display("[TB] overrun");
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        push_byte(8'h7E);
        ahb_read(4'h4, rd); checkOutput("full_ovr_status", rd, 32'h1007);
        ahb_write(4'h4, 32'h4);
        ahb_read(4'h4, rd); checkOutput("w1c_status", rd, 32'h1003);

        $display("[TB] pop and push while full");
        ahb_read_push(4'h0, 1'b1, 8'hC8, rd); checkOutput("full_pop_push", rd, 32'h100);
        ahb_read(4'h4, rd); checkOutput("full_pp_status", rd, 32'h1003);
        for (int i = 1; i < DEPTH; i++) begin
            ahb_read(4'h0, rd);
            checkOutput("drain", rd, 32'h100 | 32'(i));
        end
        ahb_read(4'h0, rd); checkOutput("drain_last_c8", rd, 32'h1C8);
        ahb_read(4'h0, rd); checkOutput("drain_empty", rd, 32'h0);

        $display("[TB] threshold interrupt");
        ahb_write(4'h8, 32'h3);
        ahb_write(4'hC, 32'h0);
        ahb_read(4'hC, rd); checkOutput("thresh_zero_as_1", rd, 32'h1);
        ahb_write(4'hC, 32'h4);
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        idle(2);
        checkOutput("irq_below", {31'b0, last_irq}, 32'h0);
        push_byte(8'h04);
        idle(1);
        checkOutput("irq_not_yet", {31'b0, last_irq}, 32'h0);
        idle(1);
        checkOutput("irq_at_thresh", {31'b0, last_irq}, 32'h1);
        ahb_read(4'h0, rd); checkOutput("irq_pop", rd, 32'h101);
        idle(2);
        checkOutput("irq_cleared", {31'b0, last_irq}, 32'h0);

        $display("[TB] flush and mid-transfer reset");
        for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i));
        ahb_write(4'h8, 32'h5);
        ahb_read(4'h4, rd); checkOutput("flush_status", rd, 32'h0);
        ahb_read(4'h8, rd); checkOutput("flush_ctrl", rd, 32'h1);
        push_byte(8'h66);
        applyStimulus(1'b1, 2'b10, 1'b1, 4'h8, 32'h0, 1'b1, 1'b0, 8'h00);
        bus.HWDATA = 32'h3;
        i_rx_dv    = 1'b1;
        i_rx_byte  = 8'h11;
        #2;
        doReset(3);
        ahb_read(4'h0, rd); checkOutput("mid_rst_data", rd, 32'h0);
        ahb_read(4'h4, rd); checkOutput("mid_rst_status", rd, 32'h0);
        ahb_read(4'h8, rd); checkOutput("mid_rst_ctrl", rd, 32'h0);
        ahb_read(4'hC, rd); checkOutput("mid_rst_thresh", rd, 32'h1);
        push_byte(8'h99);
        ahb_read(4'h4, rd); checkOutput("rx_disabled", rd, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 4000; i++) begin
            wd = $urandom;
            if ($urandom_range(0, 15) != 0) wd[2] = 1'b0;
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom), 4'($urandom), wd,
                          $urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, 8'($urandom));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
